mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the fetch stage (read-only) and the memory
//  stage (load/store) of the pipelined core. Sequences each access as one
//  request/response transaction. Gives data-side priority with bounded fetch starvation.
//  Sits between fetch_stage/memory_stage and the single-ported backing memory model.
// PARAMETERS
//  ADDR_W        32  byte-address width
//  DATA_W        32  data width (fixed 4-byte lanes; wstrb width DATA_W/8)
//  STARVE_LIMIT  4   consecutive lost arbitrations after which fetch wins once
//  CNT_W         32  width of perf counters (used only with ARB_PERF_EN)
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  if_req        in   1        fetch request, held until if_ack or if_flush
//  if_addr       in   ADDR_W   fetch byte address (bits [1:0] ignored)
//  if_flush      in   1        branch/jump redirect: drop any pending fetch response
//  if_ack        out  1        1-cycle pulse, if_rdata valid
//  if_rdata      out  DATA_W   fetched instruction
//  dm_req        in   1        data request, held stable until dm_ack
//  dm_we         in   1        1=store, 0=load
//  dm_addr       in   ADDR_W   data byte address, passed through unmodified
//  dm_wstrb      in   DATA_W/8 byte enables for stores (sb/sh/sw lanes preformatted)
//  dm_wdata      in   DATA_W   store data, lane-aligned
//  dm_ack        out  1        1-cycle pulse; dm_rdata valid for loads, 0 for stores
//  dm_rdata      out  DATA_W   raw load word (sign/zero extension done in memory_stage)
//  mem_req       out  1        backing-memory request, registered
//  mem_we / mem_addr / mem_wstrb / mem_wdata  out  registered copies of granted request
//  mem_ack       in   1        1-cycle completion pulse from memory; mem_rdata valid
//  mem_rdata     in   DATA_W   memory read data
//  perf_conflict out  CNT_W    IDLE cycles with both requests pending
//  perf_if_wait  out  CNT_W    cycles with if_req high and no if_ack
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and starve counter 0; rst mid-transaction abandons it
//   (mem_req low next edge, no ack issued); memory model must tolerate abandonment.
//  FSM IDLE -> GRANT_I|GRANT_D -> RESP_I|RESP_D -> IDLE.
//  IDLE: if dm_req and (starve<STARVE_LIMIT or !if_req) -> GRANT_D; else if if_req ->
//   GRANT_I. Request fields latched into mem_* at this edge; mem_req=1 from next cycle.
//  GRANT_x: hold mem_* stable; on mem_ack capture mem_rdata, mem_req=0 next, -> RESP_x.
//  RESP_x: x_ack=1 for exactly one cycle with captured data; -> IDLE.
//  Latency: req seen in IDLE at cycle N, mem_ack at N+1 earliest, x_ack at N+2.
//  Starve counter: +1 (saturating) on each IDLE grant to D while if_req high;
//   cleared on grant to I or when if_req low in IDLE.
//  if_flush in GRANT_I/RESP_I: memory transaction completes, if_ack suppressed;
//   if_flush and if_ack never coincide. Flush in IDLE/GRANT_D: no effect on dm side.
//  mem_addr for fetch has bits [1:0] forced 0. Store response: dm_rdata=0.
//  Simultaneous mem_ack and rst: rst wins.
// CONFIGURATION
//  ARB_PERF_EN defined: perf_conflict / perf_if_wait count, saturate at all-ones,
//   cleared by rst. Undefined: both outputs tied 0, no counter flops.
// STRUCTURE
//  Package riscv_mem_pkg: arb_state_t enum (IDLE,GRANT_I,GRANT_D,RESP_I,RESP_D),
//   ADDR_W/DATA_W defaults, mem request struct (we,addr,wstrb,wdata).
//  Single module; no sub-module needed (perf counters inline under ARB_PERF_EN).
// TESTING
//  1 fetch only, addr 0x1C, mem_ack 1 cycle after mem_req -> if_ack 2 cycles after req,
//    if_rdata=mem word, mem_addr=0x1C.
//  2 if_req+dm_req same cycle, lw 0x0 -> data granted first, fetch granted after dm_ack.
//  3 dm_req held continuously, STARVE_LIMIT=4 -> fetch granted on 5th arbitration.
//  4 sb x3,20: dm_wstrb=4'b0001, wdata=0x44 -> mem_we=1, mem_wstrb=0001, dm_rdata=0.
//  5 if_flush during GRANT_I -> no if_ack; next dm_req served normally.
//  6 rst asserted in GRANT_D -> mem_req=0 next cycle, no dm_ack, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and default bus widths.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF/8-1:0] wstrb;
    logic [DATA_W_DEF-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and backing-memory handshakes; slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = riscv_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = riscv_mem_pkg::DATA_W_DEF
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W/8-1:0]   dm_wstrb;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_ack;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; data wins unless fetch lost STARVE_LIMIT times.
// Ack two cycles after grant at best; requesters wait on ack. ARB_PERF_EN enables perf counters.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] perf_conflict_o,
  output logic [CNT_W-1:0] perf_if_wait_o
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  arb_state_t        state_q, state_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  req_t              req_q, req_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              flush_q, flush_d;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    rdata_d   = rdata_q;
    flush_d   = flush_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (bus.dm_req && ((starve_q < STV_W'(STARVE_LIMIT)) || !bus.if_req)) begin
          state_d     = GRANT_D;
          mem_req_d   = 1'b1;
          req_d.we    = bus.dm_we;
          req_d.addr  = bus.dm_addr;
          req_d.wstrb = bus.dm_wstrb;
          req_d.wdata = bus.dm_wdata;
          // Only reachable with if_req high while below the limit, so this never wraps.
          starve_d    = bus.if_req ? starve_q + STV_W'(1) : '0;
        end else if (bus.if_req) begin
          state_d     = GRANT_I;
          mem_req_d   = 1'b1;
          req_d.we    = 1'b0;
          req_d.addr  = {bus.if_addr[ADDR_W-1:2], 2'b00};
          req_d.wstrb = '0;
          req_d.wdata = '0;
          starve_d    = '0;
        end else begin
          starve_d    = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (state_q == GRANT_I && bus.if_flush) flush_d = 1'b1;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = (state_q == GRANT_D && req_q.we) ? '0 : bus.mem_rdata;
          state_d   = (state_q == GRANT_I) ? RESP_I : RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      rdata_q   <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      rdata_q   <= rdata_d;
      flush_q   <= flush_d;
    end
  end

  // A flush arriving in the response cycle itself must also kill the ack.
  assign bus.if_ack    = (state_q == RESP_I) && !flush_q && !bus.if_flush;
  assign bus.dm_ack    = (state_q == RESP_D);
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = req_q.we;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wstrb = req_q.wstrb;
  assign bus.mem_wdata = req_q.wdata;

`ifdef ARB_PERF_EN
  logic [CNT_W-1:0] conflict_q, if_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      if_wait_q  <= '0;
    end else begin
      if (state_q == IDLE && bus.dm_req && bus.if_req && !(&conflict_q))
        conflict_q <= conflict_q + CNT_W'(1);
      if (bus.if_req && !bus.if_ack && !(&if_wait_q))
        if_wait_q <= if_wait_q + CNT_W'(1);
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_if_wait_o  = if_wait_q;
`else
  assign perf_conflict_o = '0;
  assign perf_if_wait_o  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-lane memory model of configurable ack latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_conflict, perf_if_wait;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  int          mem_lat = 0;

  logic        cap_vld, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .perf_conflict_o (perf_conflict),
    .perf_if_wait_o  (perf_if_wait)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: acks mem_lat cycles after first seeing mem_req, one-cycle pulse.
  initial begin
    int wait_cnt;
    int idx;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req && !rst) begin
        if (wait_cnt >= mem_lat) begin
          idx = int'(bus.mem_addr[7:2]);
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            bus.mem_rdata = 32'hDEAD_BEEF;
          end else begin
            bus.mem_rdata = mem[idx];
          end
          bus.mem_ack = 1'b1;
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic capture_mem();
    if (bus.mem_req && !cap_vld) begin
      cap_vld   = 1'b1;
      cap_we    = bus.mem_we;
      cap_addr  = bus.mem_addr;
      cap_wstrb = bus.mem_wstrb;
      cap_wdata = bus.mem_wdata;
    end
  endtask

  task automatic dm_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wstrb = strb;
    bus.dm_wdata = wdata;
    cap_vld      = 1'b0;
    lat          = 0;
    do begin
      @(negedge clk);
      lat++;
      capture_mem();
    end while (!bus.dm_ack && lat < 40);
    rdata      = bus.dm_rdata;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    cap_vld     = 1'b0;
    lat         = 0;
    do begin
      @(negedge clk);
      lat++;
      capture_mem();
    end while (!bus.if_ack && lat < 40);
    rdata      = bus.if_rdata;
    bus.if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, cyc, n_d, n_if;

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wstrb = '0;
    bus.dm_wdata = '0;
    cap_vld      = 1'b0;
    cap_we       = 1'b0;
    cap_addr     = '0;
    cap_wstrb    = '0;
    cap_wdata    = '0;
    repeat (3) @(negedge clk);

    chk_vec("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk_vec("rst_if_ack",   {31'd0, bus.if_ack},  32'd0);
    chk_vec("rst_dm_ack",   {31'd0, bus.dm_ack},  32'd0);
    chk_vec("rst_mem_addr", bus.mem_addr,         32'd0);
    chk_vec("rst_dm_rdata", bus.dm_rdata,         32'd0);
    chk_vec("rst_perf_cf",  perf_conflict,        32'd0);
    chk_vec("rst_perf_iw",  perf_if_wait,         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only, word-aligned address.
    fetch(32'h1C, rd, lat);
    chk_vec("t1_latency",  lat,            32'd2);
    chk_vec("t1_rdata",    rd,             32'hA000_0007);
    chk_vec("t1_mem_addr", cap_addr,       32'h1C);
    chk_vec("t1_mem_we",   {31'd0, cap_we}, 32'd0);
    @(negedge clk);

    // Both request together: load first, fetch afterwards.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0;
    cyc = 0; n_if = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.if_ack) n_if++;
    end while (!bus.dm_ack && cyc < 40);
    chk_vec("t2_dm_latency", cyc,          32'd2);
    chk_vec("t2_dm_rdata",   bus.dm_rdata, 32'hA000_0000);
    chk_vec("t2_if_early",   n_if,         32'd0);
    bus.dm_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.if_ack && cyc < 40);
    chk_vec("t2_if_after",   cyc,          32'd3);
    chk_vec("t2_if_rdata",   bus.if_rdata, 32'hA000_0010);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Continuous data traffic: fetch wins the fifth arbitration.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h4;
    cyc = 0; n_d = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.dm_ack) n_d++;
    end while (!bus.if_ack && cyc < 80);
    chk_vec("t3_dm_before_if", n_d,          32'd4);
    chk_vec("t3_if_cycle",     cyc,          32'd14);
    chk_vec("t3_if_rdata",     bus.if_rdata, 32'hA000_0008);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);

    // Byte store then read-back.
    dm_access(1'b1, 32'd20, 4'b0001, 32'h0000_0044, rd, lat);
    chk_vec("t4_mem_we",    {31'd0, cap_we},   32'd1);
    chk_vec("t4_mem_wstrb", {28'd0, cap_wstrb}, 32'h1);
    chk_vec("t4_mem_wdata", cap_wdata,         32'h44);
    chk_vec("t4_mem_addr",  cap_addr,          32'd20);
    chk_vec("t4_st_rdata",  rd,                32'd0);
    chk_vec("t4_st_lat",    lat,               32'd2);
    @(negedge clk);
    dm_access(1'b0, 32'd20, 4'b0000, 32'd0, rd, lat);
    chk_vec("t4_ld_back",   rd,                32'hA000_0044);
    @(negedge clk);

    // Flush during fetch grant: memory completes, no if_ack.
    mem_lat     = 3;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_req && cyc < 10);
    chk_vec("t5_grant_seen", {31'd0, bus.mem_req}, 32'd1);
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    @(negedge clk);
    bus.if_flush = 1'b0;
    n_if = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.if_ack) n_if++;
    end
    chk_vec("t5_no_if_ack",  n_if,                 32'd0);
    chk_vec("t5_mem_done",   {31'd0, bus.mem_req}, 32'd0);
    mem_lat = 0;
    dm_access(1'b0, 32'h8, 4'b0000, 32'd0, rd, lat);
    chk_vec("t5_dm_rdata",   rd,  32'hA000_0002);
    chk_vec("t5_dm_lat",     lat, 32'd2);
    @(negedge clk);

    // Reset in the middle of a data grant abandons it.
    mem_lat      = 5;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h30;
    bus.dm_wstrb = 4'hF;
    bus.dm_wdata = 32'h1234_5678;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_req && cyc < 10);
    chk_vec("t6_grant_seen", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_vec("t6_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
    chk_vec("t6_no_dm_ack",   {31'd0, bus.dm_ack},  32'd0);
    rst        = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    mem_lat    = 0;
    n_d = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.dm_ack || bus.mem_req) n_d++;
    end
    chk_vec("t6_quiet_after", n_d, 32'd0);
    fetch(32'h1F, rd, lat);
    chk_vec("t6_fetch_lat",   lat,      32'd2);
    chk_vec("t6_fetch_addr",  cap_addr, 32'h1C);
    chk_vec("t6_fetch_rdata", rd,       32'hA000_0007);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
